// File: rtl/capture_pkg.sv
// Shared definitions for the sample capture path: sample width, header tag,
// readout FSM states and the flattened-buffer slice helper.
package capture_pkg;

  localparam int SAMPLE_BITS = 8;
  localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } rd_state_t;

  // Bit offset of sample k of channel ch in a flattened buffer vector.
  function automatic int buf_bit_offset(input int ch, input int k, input int samples);
    return (ch * samples + k) * SAMPLE_BITS;
  endfunction

endpackage

// File: rtl/next_channel_sel.sv
// Combinational search for the lowest set mask bit strictly above cur_ch,
// or the lowest set bit overall when first is asserted.
module next_channel_sel #(
  parameter int NUM_CHANNELS = 7
) (
  input  logic [NUM_CHANNELS-1:0] mask,
  input  logic [3:0]              cur_ch,
  input  logic                    first,
  output logic [3:0]              next_ch,
  output logic                    found
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur_ch)))) begin
        next_ch = 4'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_buffer_reader.sv
// Readout end of the capture path: snapshots all channel buffers on start and
// streams each enabled channel as a header byte plus its samples, oldest first.
module sample_buffer_reader
  import capture_pkg::*;
#(
  parameter int         NUM_CHANNELS = 7,
  parameter int         SAMPLES      = 10,
  parameter logic [3:0] HEADER_TAG   = HEADER_TAG_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [NUM_CHANNELS-1:0]                 ch_mask,
  input  logic [NUM_CHANNELS*SAMPLES*SAMPLE_BITS-1:0] buf_in,
  output logic [7:0]                              out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    done
);

  localparam int IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int BUF_W = NUM_CHANNELS * SAMPLES * SAMPLE_BITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

  rd_state_t               state_q, state_d;
  logic [3:0]              ch_q, ch_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic [BUF_W-1:0]        snap_q;

  logic [NUM_CHANNELS-1:0] sel_mask;
  logic [3:0]              nxt_ch;
  logic                    nxt_found;
  logic                    idx_at_last;
  logic                    capture;

  // In IDLE the search runs on the live mask so the first header is ready
  // the cycle after start; afterwards it runs on the frozen mask.
  assign sel_mask    = (state_q == IDLE) ? ch_mask : mask_q;
  assign idx_at_last = (idx_q == IDX_LAST);
  assign capture     = (state_q == IDLE) && start;

  next_channel_sel #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_sel (
    .mask   (sel_mask),
    .cur_ch (ch_q),
    .first  (state_q == IDLE),
    .next_ch(nxt_ch),
    .found  (nxt_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      if (capture) begin
        mask_q <= ch_mask;
        snap_q <= buf_in;
      end
    end
  end

  // Outputs decode only registered state, so out_ready never reaches out_valid.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (nxt_found) begin
            state_d = HDR;
            ch_d    = nxt_ch;
          end else begin
            state_d = FIN;
          end
        end
      end
      HDR: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = {HEADER_TAG, ch_q};
        if (out_ready) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = snap_q[buf_bit_offset(int'(ch_q), int'(idx_q), SAMPLES) +: SAMPLE_BITS];
        out_last  = idx_at_last && !nxt_found;
        if (out_ready) begin
          if (!idx_at_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (nxt_found) begin
            state_d = HDR;
            ch_d    = nxt_ch;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Directed bench for sample_buffer_reader: streams checked beat by beat
// against expected byte lists derived from a fixed buffer fill pattern.
module tb_sample_buffer_reader;
  localparam int NCH = 7;
  localparam int NS  = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [NCH-1:0]     ch_mask;
  logic [NCH*NS*8-1:0] buf_in;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               done;

  int n_chk  = 0;
  int n_pass = 0;

  sample_buffer_reader #(
    .NUM_CHANNELS(NCH),
    .SAMPLES     (NS),
    .HEADER_TAG  (4'hC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ch_mask  (ch_mask),
    .buf_in   (buf_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Channel c sample k = 0x10*(c+1) + k, e.g. ch0 -> 10..19, ch2 -> 30..39.
  task automatic fill_buf();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NS; k++)
        buf_in[(c*NS + k)*8 +: 8] = 8'(8'h10 * (c + 1) + k);
  endtask

  // Starts a dump at the current negedge and checks it to completion.
  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic run_dump(input logic [NCH-1:0] m, input int mode, input int disturb_at);
    logic [7:0] exp_q[$];
    int cyc, nb, nlast, last_cyc, done_cyc;
    logic rdy, pv, pl;
    logic [7:0] pd;
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        exp_q.push_back(8'hC0 | 8'(c));
        for (int k = 0; k < NS; k++) exp_q.push_back(8'(8'h10 * (c + 1) + k));
      end
    end
    start = 1'b1; ch_mask = m;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; nb = 0; nlast = 0; last_cyc = -1; done_cyc = -1; pv = 1'b0; pd = '0; pl = 1'b0;
    if (m != '0) chk("first_hdr_latency", 32'(out_valid), 32'd1);
    while (cyc < 400) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = rdy;
      if (cyc == disturb_at) begin
        start = 1'b1; ch_mask = '1; buf_in = ~buf_in;
      end else if (cyc == disturb_at + 1) begin
        start = 1'b0;
      end
      chk("busy_eq_valid", 32'(busy), 32'(out_valid));
      if (pv) begin
        chk("stall_valid_hold", 32'(out_valid), 32'd1);
        chk("stall_data_hold", 32'(out_data), 32'(pd));
        chk("stall_last_hold", 32'(out_last), 32'(pl));
      end
      pv = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          if (nb < exp_q.size()) chk($sformatf("beat%0d", nb), 32'(out_data), 32'(exp_q[nb]));
          if (out_last) begin
            nlast++;
            chk("last_position", nb, exp_q.size() - 1);
            last_cyc = cyc;
          end
          nb++;
        end else begin
          pv = 1'b1; pd = out_data; pl = out_last;
        end
      end
      if (done) begin
        done_cyc = cyc;
        chk("done_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(out_valid), 32'd0);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("no_timeout", 32'(done_cyc >= 0), 32'd1);
    chk("beat_count", nb, exp_q.size());
    chk("last_count", nlast, (exp_q.size() > 0) ? 1 : 0);
    chk("done_after_last", done_cyc - last_cyc, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ch_mask = '0; out_ready = 1'b0; buf_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    fill_buf();
    @(negedge clk);

    run_dump(7'b0000001, 0, -1);
    run_dump(7'b1000100, 0, -1);
    run_dump(7'b1000100, 1, -1);
    run_dump(7'b0000000, 0, -1);
    // Mid-dump start and buffer change must not disturb the stream.
    run_dump(7'b1000100, 0, 3);
    fill_buf();
    @(negedge clk);

    // Reset after the fifth accepted beat aborts without a done pulse.
    start = 1'b1; ch_mask = 7'b0000001; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_mid_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    reset = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("postrst_no_done", 32'(done), 32'd0);
    run_dump(7'b0000001, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sample_buffer_reader.md
Name: sample_buffer_reader

Overview:
Readout end of the multi-channel sample capture path. On start, the block freezes a snapshot of all channel sample buffers, each holding SAMPLES 8-bit samples. It then streams the enabled channels out as a byte stream over a valid/ready handshake: per channel, one header byte followed by that channel's samples, oldest first. It sits between the capture shift buffers and the byte output pins or serializer.

Parameters:
NUM_CHANNELS, 7, number of channel buffers; legal range 1..16.
SAMPLES, 10, samples per channel buffer; legal range 1..255.
HEADER_TAG, 4'hC, upper nibble of every header byte.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request a dump; honoured only in IDLE
ch_mask  in  NUM_CHANNELS  channel enable bits, sampled with start; bit i=1 means dump channel i
buf_in  in  NUM_CHANNELS*SAMPLES*8  flattened buffers; channel i = buf_in[i*SAMPLES*8 +: SAMPLES*8]; sample k = bits [k*8 +: 8] of that slice; k=0 oldest, k=SAMPLES-1 newest
out_data  out  8  stream byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_last  out  1  marks the final byte of the whole dump
busy  out  1  dump in progress
done  out  1  single-cycle pulse on dump completion

Behaviour:
- Reset: all outputs 0; state IDLE; snapshot and mask registers cleared. Reset mid-dump aborts immediately; no done pulse is issued.
- States: IDLE, HDR, DATA, FIN.
- Start handling:
  - IDLE with start=1: register buf_in and ch_mask at that edge. If the mask is nonzero, go to HDR for the lowest set channel. If the mask is zero, go to FIN.
  - start is ignored in every other state. buf_in changes after capture have no effect.
- HDR: out_valid=1, out_data={HEADER_TAG, ch[3:0]}, out_last=0. On accept, go to DATA with idx=0.
- DATA: out_valid=1, out_data=snapshot[ch][idx].
  - On accept with idx<SAMPLES-1: idx+1.
  - On accept with idx=SAMPLES-1: go to HDR of the next higher set channel, or to FIN if none remains.
- out_last=1 only in DATA, when idx=SAMPLES-1 and ch is the highest set channel.
- FIN: done=1 for exactly one cycle, then IDLE. out_valid=0.
- busy=1 in HDR and DATA only.
- Accept means out_valid&&out_ready at a rising edge.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never drops without an accept.
  - One byte per cycle when out_ready is held high.
- Latency: start at edge t gives the first header valid in cycle t+1. Last accept at edge u gives done=1 in cycle u+1. Earliest restart is start sampled in cycle u+2.
- Beat count per dump = popcount(mask)*(SAMPLES+1).
- Channel index register is 4 bits; the sample index register is clog2(SAMPLES) bits, minimum 1. The channel search is a combinational lowest-set-bit-above-ch over the registered mask.
- Only SAMPLES=1 is a special case: HDR is followed by one DATA beat.
- All outputs are registered or decoded from state registers only; no combinational path from out_ready to out_valid.

Decomposition:
- Shared package (capture_pkg): SAMPLE_BITS=8, HEADER_TAG default, state enum {IDLE,HDR,DATA,FIN}, and the buffer slice helper function (channel, sample) -> bit offset. The capture writer uses the same slice helper.
- One natural sub-module: next_channel_sel. It is combinational and takes (mask, current ch, first flag) to produce (next ch, found). It is reused by the writer for channel masking.

Test Plan:
- Reset, then start with mask=7'b0000001, buf ch0 bytes k -> 8'h10+k, out_ready=1 -> stream C0,10,11,...,19. out_last on 8'h19. done one cycle after; 11 beats total.
- mask=7'b1000100 with out_ready=1 -> C2 plus 10 ch2 bytes, then C6 plus 10 ch6 bytes. out_last only on ch6 byte 9; 22 beats.
- Same dump with out_ready toggling 1,0,0,1 repeating -> identical byte sequence. out_data stable during stalls. No duplicated or dropped bytes.
- mask=0 with start -> done pulse in cycle t+1. out_valid and busy stay 0.
- start pulsed mid-dump, plus buf_in changed after capture -> ignored; the stream matches the captured snapshot.
- reset asserted after the 5th beat -> next cycle all outputs 0 and no done pulse. A fresh start then dumps correctly from the header.
